// File: rtl/lsu_rmw.sv
// ---------------------------------------------------------------------------
// lsu_rmw -- load/store unit between the execute stage and a byte-addressed,
// word-wide data memory that always writes all four bytes.
//
// RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) are turned into aligned
// whole-word accesses. Sub-word stores become read-modify-write sequences:
// the word is read, the selected lane(s) are replaced, and the word is
// written back. Load results are lane-selected and sign/zero-extended.
//
// Parameters
//   ADDR_W       width of i_addr / o_mem_addr
//   ALIGN_CHECK  1: misaligned halfword/word accesses raise o_err
//                0: low address bits are forced to natural alignment
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req                 request strobe (sampled only in IDLE)
//   i_we                  1 = store, 0 = load
//   i_funct3              RV32I funct3 (size / signedness)
//   i_addr                byte address
//   i_wdata               store data (low bytes used for SB/SH)
//   o_busy                high while not IDLE
//   o_done                one-cycle completion pulse
//   o_err                 one-cycle error pulse, coincident with o_done
//   o_rdata               load result, held until the next load completes
//   o_mem_addr            word-aligned memory address
//   o_mem_wd              memory write word
//   o_mem_wen, o_mem_ren  memory write / read enables
//   i_mem_rd              memory read word (combinational read)
// ---------------------------------------------------------------------------
module lsu_rmw #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wd,
    output logic              o_mem_wen,
    output logic              o_mem_ren,
    input  logic [31:0]       i_mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merge;
    logic [31:0]         r_rdata;
    logic                r_err;

    // ------------------------------------------------------------------
    // Request decode (from the live inputs, used only at acceptance)
    // ------------------------------------------------------------------
    logic                w_legal;
    logic                w_misal;
    logic                w_req_err;
    logic [ADDR_W-1:0]   w_addr_fix;

    always_comb begin
        w_legal = 1'b0;
        if (i_we) begin
            w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                      (i_funct3 == 3'b010);
        end else begin
            w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                      (i_funct3 == 3'b010) || (i_funct3 == 3'b100) ||
                      (i_funct3 == 3'b101);
        end

        w_misal = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                  ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

        w_req_err = !w_legal || ((ALIGN_CHECK != 0) && w_misal);

        // Forcing natural alignment is a no-op for aligned requests, and
        // misaligned ones only survive to use this address when the check
        // is disabled, so the forcing can be applied unconditionally.
        w_addr_fix = i_addr;
        if (i_funct3[1:0] == 2'b01) begin
            w_addr_fix[0] = 1'b0;
        end else if (i_funct3[1:0] == 2'b10) begin
            w_addr_fix[1:0] = 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_req_err) begin
                        w_state_next = S_RESP;
                    end else if (!i_we) begin
                        w_state_next = S_RD;
                    end else if (i_funct3[1:0] == 2'b10) begin
                        w_state_next = S_WR;   // SW needs no read
                    end else begin
                        w_state_next = S_RD;   // SB/SH: read first, then merge
                    end
                end
            end
            S_RD:    w_state_next = r_we ? S_WR : S_RESP;
            S_WR:    w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction from the combinational memory read word
    // ------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_val;

    always_comb begin
        w_ld_byte = i_mem_rd[{r_addr[1:0], 3'b000} +: 8];
        w_ld_half = i_mem_rd[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_val = {24'h000000, w_ld_byte};
            3'b101:  w_ld_val = {16'h0000, w_ld_half};
            default: w_ld_val = i_mem_rd;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge: each byte lane takes either new store data or the word
    // captured during RD. SW selects all four lanes, so the merge register
    // never contributes to a full-word store.
    // ------------------------------------------------------------------
    logic [3:0]  w_lane_sel;
    logic [31:0] w_mem_wd;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic [7:0] w_src;

        assign w_lane_sel[gi] =
            (r_funct3[1:0] == 2'b10) ||
            ((r_funct3[1:0] == 2'b01) && (r_addr[1] == LANE[1])) ||
            ((r_funct3[1:0] == 2'b00) && (r_addr[1:0] == LANE));

        assign w_src = (r_funct3[1:0] == 2'b10) ? r_wdata[8*gi +: 8] :
                       (r_funct3[1:0] == 2'b01) ? r_wdata[8*(gi%2) +: 8] :
                                                  r_wdata[7:0];

        assign w_mem_wd[8*gi +: 8] = w_lane_sel[gi] ? w_src : r_merge[8*gi +: 8];
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == S_IDLE) && i_req) begin
                r_we     <= i_we;
                r_funct3 <= i_funct3;
                r_addr   <= w_addr_fix;
                r_wdata  <= i_wdata;
                r_err    <= w_req_err;
            end

            if (r_state == S_RD) begin
                if (r_we) begin
                    r_merge <= i_mem_rd;
                end else begin
                    r_rdata <= w_ld_val;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Enables are gated by reset so a reset landing in WR/RD never touches
    // memory in that cycle.
    assign o_mem_ren  = (r_state == S_RD) && !i_rst;
    assign o_mem_wen  = (r_state == S_WR) && !i_rst;
    assign o_mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_mem_wd   = w_mem_wd;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_RESP);
    assign o_err      = (r_state == S_RESP) && r_err;
    assign o_rdata    = r_rdata;

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit sitting between the execute stage and the byte-addressed data memory.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned whole-word memory accesses.
- The memory writes all four bytes on every write, so SB and SH are done as read-modify-write sequences.
- Loads return a lane-selected, sign- or zero-extended result; misaligned or illegal requests are flagged with o_err.

Parameters:
- ADDR_W, 32, width of i_addr and o_mem_addr.
- ALIGN_CHECK, 1. When 1, misaligned halfword and word accesses raise o_err. When 0, the low address bits are forced to the natural alignment and the access completes.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3 (size and signedness).
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  32  store data, taken from the low bytes.
- o_busy  out  1  high whenever state is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle pulse, coincident with o_done, on a misaligned or illegal request.
- o_rdata  out  32  load result; holds until the next load completes.
- o_mem_addr  out  ADDR_W  word-aligned address: latched address with bits [1:0] = 0.
- o_mem_wd  out  32  write word to memory.
- o_mem_wen  out  1  memory write enable.
- o_mem_ren  out  1  memory read enable.
- i_mem_rd  in  32  memory read word; combinational (same-cycle) read.

Behaviour:
- Reset values: state IDLE; o_busy, o_done, o_err, o_mem_wen, o_mem_ren = 0; o_rdata, o_mem_addr, o_mem_wd = 0; internal latches = 0.
- Request acceptance: in IDLE with i_req=1 at an edge, latch i_we, i_funct3, i_addr, i_wdata. While busy, i_req is ignored; there is no queueing.
- States: IDLE, RD, WR, RESP.
- Load: IDLE -> RD -> RESP -> IDLE.
  - In RD: o_mem_ren=1. At the edge, o_rdata <= extracted i_mem_rd.
- SW: IDLE -> WR -> RESP. In WR: o_mem_wen=1, o_mem_wd = latched wdata.
- SB/SH: IDLE -> RD -> WR -> RESP.
  - At the RD edge, capture i_mem_rd into the merge register.
  - In WR: o_mem_wd = merge register with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
- Error path: IDLE -> RESP directly, with o_err=1 in RESP. No memory enable is asserted, and o_rdata is unchanged.
- RESP: o_done=1 for exactly one cycle, then IDLE. A new i_req may be accepted at the edge leaving RESP? No: acceptance happens only in IDLE.
- Latency, counted from the accepting edge E:
  - loads and SW: o_done high in the cycle after E+1;
  - SB/SH: o_done high in the cycle after E+2;
  - errors: o_done high in the cycle after E.
- Lane select: byte lane = addr[1:0]; halfword lane = addr[1]. Lane 0 is bits [7:0] (little-endian).
- Load extension:
  - LB/LH sign-extend from bit 7 / bit 15;
  - LBU/LHU zero-extend;
  - LW passes the word through.
- Legal funct3:
  - loads: 000, 001, 010, 100, 101;
  - stores: 000, 001, 010;
  - all others are illegal and take the error path.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Handled per ALIGN_CHECK.
- o_mem_wen and o_mem_ren are combinational from state and gated by !i_rst. Reset asserted during WR therefore causes no memory write.
- Reset mid-operation: at the next edge the state returns to IDLE; o_done does not pulse and the partial merge is discarded.
- o_mem_addr is stable for the whole access. Outside RD/WR, o_mem_wen and o_mem_ren are 0.

Test Plan:
- Memory word 0x100 = 0x887766F5.
  - LB @0x100 -> o_rdata=0xFFFFFFF5.
  - LBU @0x103 -> 0x00000088.
  - LH @0x102 -> 0xFFFF8877.
  - Each with o_done 2 cycles after the accepting edge; o_mem_wen never asserted.
- SH i_wdata=0x1234BEEF @0x102 on word 0x887766F5 -> memory becomes 0xBEEF66F5. o_mem_ren is high for exactly one cycle, then o_mem_wen for exactly one cycle; o_done 3 cycles after acceptance.
- SB 0xAA @0x101, then LW @0x100 -> 0x8877AAF5. SW 0xDEADBEEF @0x104, then LW @0x104 -> 0xDEADBEEF.
- SW @0x101 with ALIGN_CHECK=1 -> o_err=1 and o_done=1 in the same single cycle, memory unchanged, o_rdata unchanged. LW with funct3=011 -> same error response.
- Assert i_rst while in WR of an SB -> o_mem_wen=0 that cycle, memory unchanged, next cycle o_busy=0, no o_done.
- Hold i_req=1 continuously with distinct requests while busy -> only the request present in IDLE is executed. o_busy deasserts for one cycle between accesses.
